// File: rtl/eth_rx_ingress.sv
// Store-and-forward Ethernet RX ingress: buffers frames, drops bad ones,
// tags good frames local/remote and forwards them on an AXI-Stream master.
//
// Ports:
//   i_clk, i_rst            clock, async active-high reset
//   i_stat_rx_status        MAC link status (1 = up)
//   s_axis_rx_*             MAC RX stream (no ready)
//   m_axis_*                output stream, tuser=remote, tdest=local port
//   o_rx_frame_cnt          good frames committed
//   o_rx_drop_cnt           frames dropped
//   o_drop_pulse            one-cycle pulse per drop
module eth_rx_ingress #(
  parameter int          P_DATA_W          = 64,
  parameter int          P_DATA_DEPTH_LOG2 = 9,
  parameter int          P_DESC_DEPTH_LOG2 = 4,
  parameter logic [47:0] P_MY_TOR_MAC      = 48'h8DBC5C4A0000,
  parameter int          P_DEST_W          = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_stat_rx_status,
  input  logic                  s_axis_rx_tvalid,
  input  logic [P_DATA_W-1:0]   s_axis_rx_tdata,
  input  logic [P_DATA_W/8-1:0] s_axis_rx_tkeep,
  input  logic                  s_axis_rx_tlast,
  input  logic                  s_axis_rx_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [P_DATA_W-1:0]   m_axis_tdata,
  output logic [P_DATA_W/8-1:0] m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic [P_DEST_W-1:0]   m_axis_tdest,
  output logic [31:0]           o_rx_frame_cnt,
  output logic [31:0]           o_rx_drop_cnt,
  output logic                  o_drop_pulse
);

  localparam int KW = P_DATA_W / 8;
  localparam int AW = P_DATA_DEPTH_LOG2;
  localparam int DW = P_DESC_DEPTH_LOG2;
  localparam int EW = 16 + 1 + P_DEST_W;
  localparam int BW = P_DATA_W + KW;

  localparam logic [AW:0] DEPTH  = {1'b1, {AW{1'b0}}};
  localparam logic [DW:0] DDEPTH = {1'b1, {DW{1'b0}}};

  localparam logic [1:0] S_SYNC  = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_FRAME = 2'd2;
  localparam logic [1:0] S_DISC  = 2'd3;

  localparam logic [1:0] O_IDLE = 2'd0;
  localparam logic [1:0] O_LOAD = 2'd1;
  localparam logic [1:0] O_SEND = 2'd2;

  logic [BW-1:0] dmem [2**AW];
  logic [EW-1:0] emem [2**DW];

  logic [1:0]          in_st;
  logic [1:0]          in_nx;
  logic [AW:0]         wr_ptr;
  logic [AW:0]         wr_cmt;
  logic [AW:0]         rd_ptr;
  logic [DW:0]         dw_ptr;
  logic [DW:0]         dr_ptr;
  logic [15:0]         len_cnt;
  logic [15:0]         len_nx;
  logic                frm_loc;
  logic [P_DEST_W-1:0] frm_dst;

  logic [47:0]         beat_mac;
  logic                beat_loc;
  logic                first;
  logic                cur_loc;
  logic [P_DEST_W-1:0] cur_dst;
  logic                buf_full;
  logic                desc_full;
  logic                desc_empty;
  logic                blast;
  logic                wr_en;
  logic                end_frm;
  logic                abort;
  logic                commit;
  logic                drop;
  logic                unused_mac;

  always_comb begin
    beat_mac = '0;
    for (int i = 0; i < 6; i++)
      beat_mac[47-8*i -: 8] = s_axis_rx_tdata[8*i +: 8];
  end

  assign unused_mac = ^beat_mac;
  assign beat_loc   = beat_mac[47:8] == P_MY_TOR_MAC[47:8];
  assign first      = in_st == S_IDLE;
  assign cur_loc    = first ? beat_loc : frm_loc;
  assign cur_dst    = first ? beat_mac[P_DEST_W-1:0] : frm_dst;
  assign len_nx     = first ? 16'd1 : len_cnt + 16'd1;
  assign buf_full   = (wr_ptr - rd_ptr) == DEPTH;
  assign desc_full  = (dw_ptr - dr_ptr) == DDEPTH;
  assign desc_empty = dw_ptr == dr_ptr;
  assign blast      = s_axis_rx_tvalid && s_axis_rx_tlast;

  always_comb begin
    in_nx   = in_st;
    wr_en   = 1'b0;
    end_frm = 1'b0;
    abort   = 1'b0;
    unique case (in_st)
      S_SYNC: begin
        if (!s_axis_rx_tvalid || s_axis_rx_tlast)
          in_nx = S_IDLE;
      end
      S_IDLE: begin
        if (!i_stat_rx_status) begin
          in_nx = S_SYNC;
        end else if (s_axis_rx_tvalid) begin
          if (buf_full) begin
            abort = s_axis_rx_tlast;
            in_nx = s_axis_rx_tlast ? S_IDLE : S_DISC;
          end else begin
            wr_en   = 1'b1;
            end_frm = s_axis_rx_tlast;
            in_nx   = s_axis_rx_tlast ? S_IDLE : S_FRAME;
          end
        end
      end
      S_FRAME: begin
        if (!i_stat_rx_status ||
            (s_axis_rx_tvalid && buf_full)) begin
          abort = blast;
          in_nx = blast ? S_IDLE : S_DISC;
        end else if (s_axis_rx_tvalid) begin
          wr_en   = 1'b1;
          end_frm = s_axis_rx_tlast;
          if (s_axis_rx_tlast)
            in_nx = S_IDLE;
        end
      end
      default: begin
        if (blast) begin
          abort = 1'b1;
          in_nx = S_IDLE;
        end
      end
    endcase
  end

  assign commit = end_frm && !s_axis_rx_tuser &&
                  i_stat_rx_status && !desc_full;
  assign drop   = abort || (end_frm && !commit);

  always_ff @(posedge i_clk) begin
    if (wr_en)
      dmem[wr_ptr[AW-1:0]] <= {s_axis_rx_tkeep, s_axis_rx_tdata};
    if (commit)
      emem[dw_ptr[DW-1:0]] <= {len_nx, cur_loc, cur_dst};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      in_st          <= S_SYNC;
      wr_ptr         <= '0;
      wr_cmt         <= '0;
      dw_ptr         <= '0;
      len_cnt        <= '0;
      frm_loc        <= 1'b0;
      frm_dst        <= '0;
      o_rx_frame_cnt <= '0;
      o_rx_drop_cnt  <= '0;
      o_drop_pulse   <= 1'b0;
    end else begin
      in_st        <= in_nx;
      o_drop_pulse <= drop;
      if (drop) begin
        wr_ptr        <= wr_cmt;
        o_rx_drop_cnt <= o_rx_drop_cnt + 32'd1;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (commit) begin
        wr_cmt         <= wr_ptr + 1'b1;
        dw_ptr         <= dw_ptr + 1'b1;
        o_rx_frame_cnt <= o_rx_frame_cnt + 32'd1;
      end
      if (wr_en)
        len_cnt <= len_nx;
      if (wr_en && first) begin
        frm_loc <= beat_loc;
        frm_dst <= beat_mac[P_DEST_W-1:0];
      end
    end
  end

  logic [1:0]    o_st;
  logic [15:0]   o_len;
  logic [15:0]   o_cnt;
  logic [AW:0]   rd_nx;
  logic [EW-1:0] desc_rd;
  logic          hs;

  assign rd_nx   = rd_ptr + 1'b1;
  assign desc_rd = emem[dr_ptr[DW-1:0]];
  assign hs      = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_st          <= O_IDLE;
      rd_ptr        <= '0;
      dr_ptr        <= '0;
      o_len         <= '0;
      o_cnt         <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tdest  <= '0;
    end else begin
      unique case (o_st)
        O_IDLE: begin
          if (!desc_empty) begin
            dr_ptr       <= dr_ptr + 1'b1;
            o_len        <= desc_rd[EW-1 -: 16];
            m_axis_tuser <= !desc_rd[P_DEST_W];
            m_axis_tdest <= desc_rd[P_DEST_W] ?
                            desc_rd[P_DEST_W-1:0] : '0;
            o_st         <= O_LOAD;
          end
        end
        O_LOAD: begin
          {m_axis_tkeep, m_axis_tdata} <= dmem[rd_ptr[AW-1:0]];
          m_axis_tvalid <= 1'b1;
          m_axis_tlast  <= o_len == 16'd1;
          o_cnt         <= 16'd1;
          o_st          <= O_SEND;
        end
        default: begin
          if (hs) begin
            rd_ptr <= rd_nx;
            if (m_axis_tlast) begin
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              o_st          <= O_IDLE;
            end else begin
              {m_axis_tkeep, m_axis_tdata} <= dmem[rd_nx[AW-1:0]];
              o_cnt        <= o_cnt + 16'd1;
              m_axis_tlast <= (o_cnt + 16'd1) == o_len;
            end
          end
        end
      endcase
    end
  end

endmodule
